// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone slave between up to four masters.
// A grant is held for the whole CYC; a watchdog turns a missing ACK into an error pulse.
module wb_rr_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                                 wb_clk,
   input  logic                                 wb_rst,
   input  logic [NUM_MASTERS-1:0]               m_cyc_i,
   input  logic [NUM_MASTERS-1:0]               m_stb_i,
   input  logic [NUM_MASTERS-1:0]               m_we_i,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_adr_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i,
   input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_sel_i,
   output logic [DATA_WIDTH-1:0]                m_dat_o,
   output logic [NUM_MASTERS-1:0]               m_ack_o,
   output logic [NUM_MASTERS-1:0]               m_err_o,
   output logic                                 s_cyc_o,
   output logic                                 s_stb_o,
   output logic                                 s_we_o,
   output logic [ADDR_WIDTH-1:0]                s_adr_o,
   output logic [DATA_WIDTH-1:0]                s_dat_o,
   output logic [(DATA_WIDTH/8)-1:0]            s_sel_o,
   input  logic [DATA_WIDTH-1:0]                s_dat_i,
   input  logic                                 s_ack_i,
   output logic [NUM_MASTERS-1:0]               grant_o,
   output logic                                 busy_o
);

   localparam int SEL_WIDTH = DATA_WIDTH / 8;
   localparam int PTR_W     = (NUM_MASTERS > 2) ? 2 : 1;
   localparam int WD_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [NUM_MASTERS-1:0] err_q, err_d;
   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic [WD_W-1:0]        wdog_q, wdog_d;

   logic [NUM_MASTERS-1:0] pick_oh;
   int                     best_off;
   logic                   busy;
   logic                   g_cyc, g_stb, g_we;
   logic [ADDR_WIDTH-1:0]  g_adr;
   logic [DATA_WIDTH-1:0]  g_dat;
   logic [SEL_WIDTH-1:0]   g_sel;
   logic [PTR_W-1:0]       rel_ptr;

   // Winner is the requester with the smallest distance above the pointer.
   always_comb begin : rr_pick
      pick_oh  = '0;
      best_off = NUM_MASTERS;
      for (int j = 0; j < NUM_MASTERS; j++) begin
         if (m_cyc_i[j] && ((j + NUM_MASTERS - int'(ptr_q)) % NUM_MASTERS) < best_off) begin
            best_off   = (j + NUM_MASTERS - int'(ptr_q)) % NUM_MASTERS;
            pick_oh    = '0;
            pick_oh[j] = 1'b1;
         end
      end
   end

   // Grant is one-hot, so an AND-OR select is enough for the slave mux.
   always_comb begin : slave_mux
      g_cyc   = 1'b0;
      g_stb   = 1'b0;
      g_we    = 1'b0;
      g_adr   = '0;
      g_dat   = '0;
      g_sel   = '0;
      rel_ptr = '0;
      for (int j = 0; j < NUM_MASTERS; j++) begin
         if (grant_q[j]) begin
            g_cyc   = m_cyc_i[j];
            g_stb   = m_stb_i[j];
            g_we    = m_we_i[j];
            g_adr   = m_adr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
            g_dat   = m_dat_i[j*DATA_WIDTH +: DATA_WIDTH];
            g_sel   = m_sel_i[j*SEL_WIDTH +: SEL_WIDTH];
            rel_ptr = PTR_W'((j + 1) % NUM_MASTERS);
         end
      end
   end

   always_comb begin : next_state
      // NOTE: every _d gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      wdog_d  = '0;
      err_d   = '0;
      case (state_q)
         IDLE: begin
            if (|m_cyc_i) begin
               state_d = BUSY;
               grant_d = pick_oh;
            end
         end
         BUSY: begin
            if (!g_cyc) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = rel_ptr;
            end else if (TIMEOUT_CYCLES != 0 && g_stb && !s_ack_i && !(|err_q)) begin
               // An ACK in the expiry cycle lands in the else-path above and wins.
               if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) err_d = grant_q;
               else                                     wdog_d = wdog_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: async reset in the sensitivity list and <= for every register so all state updates see pre-edge values.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         err_q   <= '0;
         ptr_q   <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         err_q   <= err_d;
         ptr_q   <= ptr_d;
         wdog_q  <= wdog_d;
      end
   end

   assign busy    = (state_q == BUSY);
   assign busy_o  = busy;
   assign grant_o = grant_q;
   assign m_err_o = err_q;
   assign m_dat_o = s_dat_i;
   assign m_ack_o = busy ? (grant_q & {NUM_MASTERS{s_ack_i}}) : '0;

   assign s_cyc_o = busy & g_cyc;
   assign s_stb_o = busy & g_stb & ~(|err_q);
   assign s_we_o  = busy & g_we;
   assign s_adr_o = busy ? g_adr : '0;
   assign s_dat_o = busy ? g_dat : '0;
   assign s_sel_o = busy ? g_sel : '0;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: vector table, hand-written corner sequences and a
// randomized phase checked against a cycle-level reference model.
module tb_wb_rr_arbiter;

   localparam int NM = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 8;
   localparam logic [31:0] DAT0 = 32'hDEADBEEF;
   localparam logic [31:0] DAT1 = 32'h12345678;

   logic             wb_clk = 1'b0;
   logic             wb_rst;
   logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i;
   logic [NM*AW-1:0] m_adr_i;
   logic [NM*DW-1:0] m_dat_i;
   logic [NM*SW-1:0] m_sel_i;
   logic [DW-1:0]    m_dat_o;
   logic [NM-1:0]    m_ack_o, m_err_o;
   logic             s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0]    s_adr_o;
   logic [DW-1:0]    s_dat_o;
   logic [SW-1:0]    s_sel_o;
   logic [DW-1:0]    s_dat_i;
   logic             s_ack_i;
   logic [NM-1:0]    grant_o;
   logic             busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 wb_clk = ~wb_clk;

   wb_rr_arbiter #(
      .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .grant_o(grant_o), .busy_o(busy_o)
   );

   typedef struct {
      logic [1:0]  cyc, stb, we;
      logic [31:0] a0, a1;
      logic        ack;
      logic [1:0]  g;
      logic        scyc, sstb;
      logic [31:0] sadr;
      logic [1:0]  mack, merr;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] cyc, stb, we, input logic [31:0] a0, a1,
                               input logic ack, input logic [1:0] g, input logic scyc, sstb,
                               input logic [31:0] sadr, input logic [1:0] mack, merr);
      vec_t v;
      v.cyc = cyc; v.stb = stb; v.we = we; v.a0 = a0; v.a1 = a1; v.ack = ack;
      v.g = g; v.scyc = scyc; v.sstb = sstb; v.sadr = sadr; v.mack = mack; v.merr = merr;
      return v;
   endfunction

   // Drive one cycle of inputs, check mid-cycle, then advance to just after the next edge.
   task automatic apply(input vec_t v, input string tag);
      logic [31:0] e_dat;
      logic [3:0]  e_sel;
      logic        e_we;
      m_cyc_i = v.cyc;
      m_stb_i = v.stb;
      m_we_i  = v.we;
      m_adr_i = {v.a1, v.a0};
      s_ack_i = v.ack;
      s_dat_i = $urandom;
      e_dat = v.g[0] ? DAT0 : (v.g[1] ? DAT1 : 32'h0);
      e_sel = v.g[0] ? 4'hF : (v.g[1] ? 4'h3 : 4'h0);
      e_we  = |(v.g & v.we);
      #3;
      check($sformatf("%s grant", tag), grant_o, v.g);
      check($sformatf("%s busy", tag), busy_o, |v.g);
      check($sformatf("%s s_cyc", tag), s_cyc_o, v.scyc);
      check($sformatf("%s s_stb", tag), s_stb_o, v.sstb);
      check($sformatf("%s s_we", tag), s_we_o, e_we);
      check($sformatf("%s s_adr", tag), s_adr_o, v.sadr);
      check($sformatf("%s s_dat", tag), s_dat_o, e_dat);
      check($sformatf("%s s_sel", tag), s_sel_o, e_sel);
      check($sformatf("%s m_ack", tag), m_ack_o, v.mack);
      check($sformatf("%s m_err", tag), m_err_o, v.merr);
      check($sformatf("%s m_dat", tag), m_dat_o, s_dat_i);
      @(posedge wb_clk);
      #1;
   endtask

   vec_t tbl[18];

   // Reference model state for the random phase.
   logic        cyc_a[NM], stb_a[NM];
   logic [31:0] adr_a[NM];
   int          owner, prio, wd, ack_prob;
   logic [1:0]  err_now, nxt_err, e_g, e_ack;
   logic        e_stb, e_cyc, ack;
   logic [31:0] e_adr;

   initial begin
      m_dat_i = {DAT1, DAT0};
      m_sel_i = {4'h3, 4'hF};
      s_dat_i = '0;
      m_we_i  = '0;
      m_adr_i = '0;

      // Reset holds everything quiet even with requests and a stray ACK present.
      wb_rst  = 1'b1;
      m_cyc_i = 2'b11;
      m_stb_i = 2'b11;
      s_ack_i = 1'b1;
      repeat (2) @(posedge wb_clk);
      #1;
      check("reset grant", grant_o, 2'b00);
      check("reset busy", busy_o, 1'b0);
      check("reset s_cyc", s_cyc_o, 1'b0);
      check("reset s_stb", s_stb_o, 1'b0);
      check("reset s_adr", s_adr_o, 32'h0);
      check("reset m_ack", m_ack_o, 2'b00);
      check("reset m_err", m_err_o, 2'b00);
      wb_rst = 1'b0;

      // Both masters doing single reads, slave ACKs at once: grants alternate 0,1,0,1.
      tbl[0]  = mk(2'b11, 2'b11, 2'b00, 32'h40, 32'h80, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 2'b00);
      tbl[1]  = mk(2'b11, 2'b11, 2'b00, 32'h40, 32'h80, 1'b1, 2'b01, 1'b1, 1'b1, 32'h40, 2'b01, 2'b00);
      tbl[2]  = mk(2'b10, 2'b10, 2'b00, 32'h40, 32'h80, 1'b0, 2'b01, 1'b0, 1'b0, 32'h40, 2'b00, 2'b00);
      tbl[3]  = mk(2'b11, 2'b11, 2'b00, 32'h40, 32'h80, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 2'b00);
      tbl[4]  = mk(2'b11, 2'b11, 2'b00, 32'h40, 32'h80, 1'b1, 2'b10, 1'b1, 1'b1, 32'h80, 2'b10, 2'b00);
      tbl[5]  = mk(2'b01, 2'b01, 2'b00, 32'h40, 32'h80, 1'b0, 2'b10, 1'b0, 1'b0, 32'h80, 2'b00, 2'b00);
      tbl[6]  = mk(2'b11, 2'b11, 2'b00, 32'h40, 32'h80, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 2'b00);
      tbl[7]  = mk(2'b11, 2'b11, 2'b00, 32'h40, 32'h80, 1'b1, 2'b01, 1'b1, 1'b1, 32'h40, 2'b01, 2'b00);
      tbl[8]  = mk(2'b10, 2'b10, 2'b00, 32'h40, 32'h80, 1'b0, 2'b01, 1'b0, 1'b0, 32'h40, 2'b00, 2'b00);
      tbl[9]  = mk(2'b11, 2'b11, 2'b00, 32'h40, 32'h80, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 2'b00);
      tbl[10] = mk(2'b11, 2'b11, 2'b00, 32'h40, 32'h80, 1'b1, 2'b10, 1'b1, 1'b1, 32'h80, 2'b10, 2'b00);
      tbl[11] = mk(2'b01, 2'b01, 2'b00, 32'h40, 32'h80, 1'b0, 2'b10, 1'b0, 1'b0, 32'h80, 2'b00, 2'b00);
      // Single write by master 0, ACK two cycles after the first strobe.
      tbl[12] = mk(2'b01, 2'b01, 2'b01, 32'h10, 32'h0,  1'b0, 2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 2'b00);
      tbl[13] = mk(2'b01, 2'b01, 2'b01, 32'h10, 32'h0,  1'b0, 2'b01, 1'b1, 1'b1, 32'h10, 2'b00, 2'b00);
      tbl[14] = mk(2'b01, 2'b01, 2'b01, 32'h10, 32'h0,  1'b0, 2'b01, 1'b1, 1'b1, 32'h10, 2'b00, 2'b00);
      tbl[15] = mk(2'b01, 2'b01, 2'b01, 32'h10, 32'h0,  1'b1, 2'b01, 1'b1, 1'b1, 32'h10, 2'b01, 2'b00);
      tbl[16] = mk(2'b00, 2'b00, 2'b00, 32'h10, 32'h0,  1'b0, 2'b01, 1'b0, 1'b0, 32'h10, 2'b00, 2'b00);
      tbl[17] = mk(2'b00, 2'b00, 2'b00, 32'h10, 32'h0,  1'b0, 2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 2'b00);
      for (int r = 0; r < 18; r++) apply(tbl[r], $sformatf("vec%0d", r));

      // Burst: master 1 keeps CYC for three writes while master 0 waits.
      apply(mk(2'b10, 2'b10, 2'b10, 32'h0,   32'h100, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,   2'b00, 2'b00), "burst arb");
      apply(mk(2'b11, 2'b11, 2'b10, 32'h200, 32'h100, 1'b1, 2'b10, 1'b1, 1'b1, 32'h100, 2'b10, 2'b00), "burst w0");
      apply(mk(2'b11, 2'b11, 2'b10, 32'h200, 32'h104, 1'b1, 2'b10, 1'b1, 1'b1, 32'h104, 2'b10, 2'b00), "burst w1");
      apply(mk(2'b11, 2'b11, 2'b10, 32'h200, 32'h108, 1'b1, 2'b10, 1'b1, 1'b1, 32'h108, 2'b10, 2'b00), "burst w2");
      apply(mk(2'b01, 2'b01, 2'b00, 32'h200, 32'h108, 1'b0, 2'b10, 1'b0, 1'b0, 32'h108, 2'b00, 2'b00), "burst rel");
      apply(mk(2'b01, 2'b01, 2'b00, 32'h200, 32'h0,   1'b0, 2'b00, 1'b0, 1'b0, 32'h0,   2'b00, 2'b00), "burst dead");
      apply(mk(2'b01, 2'b01, 2'b00, 32'h200, 32'h0,   1'b1, 2'b01, 1'b1, 1'b1, 32'h200, 2'b01, 2'b00), "burst m0");
      apply(mk(2'b00, 2'b00, 2'b00, 32'h200, 32'h0,   1'b0, 2'b01, 1'b0, 1'b0, 32'h200, 2'b00, 2'b00), "burst m0 rel");

      // Timeout: master 1 reads, slave never answers.
      apply(mk(2'b10, 2'b10, 2'b00, 32'h0, 32'h300, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00), "to arb");
      for (int k = 0; k < TO; k++)
         apply(mk(2'b10, 2'b10, 2'b00, 32'h0, 32'h300, 1'b0, 2'b10, 1'b1, 1'b1, 32'h300, 2'b00, 2'b00),
               $sformatf("to wait%0d", k));
      apply(mk(2'b10, 2'b10, 2'b00, 32'h0,   32'h300, 1'b0, 2'b10, 1'b1, 1'b0, 32'h300, 2'b00, 2'b10), "to err");
      apply(mk(2'b01, 2'b01, 2'b00, 32'h200, 32'h300, 1'b0, 2'b10, 1'b0, 1'b0, 32'h300, 2'b00, 2'b00), "to drop");
      apply(mk(2'b01, 2'b01, 2'b00, 32'h200, 32'h300, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,   2'b00, 2'b00), "to dead");
      apply(mk(2'b01, 2'b01, 2'b00, 32'h200, 32'h300, 1'b1, 2'b01, 1'b1, 1'b1, 32'h200, 2'b01, 2'b00), "to m0");
      apply(mk(2'b00, 2'b00, 2'b00, 32'h200, 32'h300, 1'b0, 2'b01, 1'b0, 1'b0, 32'h200, 2'b00, 2'b00), "to m0 rel");

      // ACK in the cycle the watchdog would expire: ACK wins, no error follows.
      apply(mk(2'b01, 2'b01, 2'b00, 32'h200, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00), "race arb");
      for (int k = 0; k < TO - 1; k++)
         apply(mk(2'b01, 2'b01, 2'b00, 32'h200, 32'h0, 1'b0, 2'b01, 1'b1, 1'b1, 32'h200, 2'b00, 2'b00),
               $sformatf("race wait%0d", k));
      apply(mk(2'b01, 2'b01, 2'b00, 32'h200, 32'h0, 1'b1, 2'b01, 1'b1, 1'b1, 32'h200, 2'b01, 2'b00), "race ack");
      apply(mk(2'b01, 2'b01, 2'b00, 32'h200, 32'h0, 1'b0, 2'b01, 1'b1, 1'b1, 32'h200, 2'b00, 2'b00), "race no err");
      apply(mk(2'b00, 2'b00, 2'b00, 32'h200, 32'h0, 1'b0, 2'b01, 1'b0, 1'b0, 32'h200, 2'b00, 2'b00), "race rel");

      // Reset between edges while master 1 owns the bus; pointer must return to 0.
      apply(mk(2'b11, 2'b11, 2'b00, 32'h200, 32'h300, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00), "rst arb");
      #1;
      check("rst pre grant", grant_o, 2'b10);
      wb_rst = 1'b1;
      #1;
      check("rst mid grant", grant_o, 2'b00);
      check("rst mid s_cyc", s_cyc_o, 1'b0);
      check("rst mid s_stb", s_stb_o, 1'b0);
      check("rst mid busy", busy_o, 1'b0);
      @(posedge wb_clk);
      #1;
      wb_rst = 1'b0;
      apply(mk(2'b11, 2'b11, 2'b00, 32'h200, 32'h300, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,   2'b00, 2'b00), "rst idle");
      apply(mk(2'b11, 2'b11, 2'b00, 32'h200, 32'h300, 1'b1, 2'b01, 1'b1, 1'b1, 32'h200, 2'b01, 2'b00), "rst m0 wins");
      apply(mk(2'b00, 2'b00, 2'b00, 32'h200, 32'h300, 1'b0, 2'b01, 1'b0, 1'b0, 32'h200, 2'b00, 2'b00), "rst rel");

      // Random phase against the reference model, starting from a fresh reset.
      wb_rst = 1'b1;
      #1;
      wb_rst = 1'b0;
      @(posedge wb_clk);
      #1;
      owner = -1; prio = 0; wd = 0; err_now = '0; ack_prob = 50;
      for (int i = 0; i < NM; i++) begin
         cyc_a[i] = 1'b0; stb_a[i] = 1'b0; adr_a[i] = '0;
      end
      for (int n = 0; n < 1500; n++) begin
         if (n % 40 == 0) ack_prob = ($urandom_range(2) == 0) ? 0 : int'($urandom_range(80, 20));
         for (int i = 0; i < NM; i++) begin
            if (cyc_a[i]) cyc_a[i] = ($urandom_range(99) >= 6);
            else          cyc_a[i] = ($urandom_range(99) < 30);
            stb_a[i] = cyc_a[i] && ($urandom_range(9) != 0);
            adr_a[i] = $urandom;
         end
         ack = (int'($urandom_range(99)) < ack_prob);
         m_cyc_i = {cyc_a[1], cyc_a[0]};
         m_stb_i = {stb_a[1], stb_a[0]};
         m_we_i  = 2'($urandom);
         m_adr_i = {adr_a[1], adr_a[0]};
         s_ack_i = ack;
         s_dat_i = $urandom;

         e_g = '0;
         for (int i = 0; i < NM; i++) e_g[i] = (owner == i);
         e_cyc = (owner >= 0) && cyc_a[owner];
         e_stb = (owner >= 0) && stb_a[owner] && (err_now == '0);
         e_adr = (owner >= 0) ? adr_a[owner] : 32'h0;
         e_ack = (owner >= 0 && ack) ? e_g : 2'b00;
         #3;
         check($sformatf("rand%0d grant", n), grant_o, e_g);
         check($sformatf("rand%0d s_cyc", n), s_cyc_o, e_cyc);
         check($sformatf("rand%0d s_stb", n), s_stb_o, e_stb);
         check($sformatf("rand%0d s_adr", n), s_adr_o, e_adr);
         check($sformatf("rand%0d m_ack", n), m_ack_o, e_ack);
         check($sformatf("rand%0d m_err", n), m_err_o, err_now);

         nxt_err = '0;
         if (owner < 0) begin
            wd = 0;
            for (int k = 0; k < NM; k++)
               if (owner < 0 && cyc_a[(prio + k) % NM]) owner = (prio + k) % NM;
         end else if (!cyc_a[owner]) begin
            prio  = (owner + 1) % NM;
            owner = -1;
            wd    = 0;
         end else if (stb_a[owner] && !ack && err_now == '0) begin
            wd++;
            if (wd == TO) begin
               nxt_err = e_g;
               wd      = 0;
            end
         end else begin
            wd = 0;
         end
         err_now = nxt_err;
         @(posedge wb_clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin arbiter that shares one classic (non-pipelined) Wishbone slave port between up to four Wishbone masters, e.g. simulation bus-functional masters, the register-access bridge and debug agents in the BPM gateware. A granted master owns the slave bus for as long as it holds CYC, so multi-transfer bursts stay atomic. A watchdog terminates hung transfers with an error pulse so that a missing slave ACK cannot deadlock the bus.

## Interface

Parameters:
- NUM_MASTERS, 2: number of requesters, legal range 2..4.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width; select width SEL_WIDTH = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256: watchdog limit in cycles; 0 disables the watchdog.

Ports. Master vectors are packed, with master i at slice i.
- wb_clk  in  1  bus clock; all logic on its rising edge.
- wb_rst  in  1  reset, asynchronous, active-high.
- m_cyc_i  in  NUM_MASTERS  per-master CYC; acts as the request.
- m_stb_i  in  NUM_MASTERS  per-master STB.
- m_we_i  in  NUM_MASTERS  per-master WE.
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  per-master address.
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  per-master write data.
- m_sel_i  in  NUM_MASTERS*SEL_WIDTH  per-master byte select.
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters (= s_dat_i).
- m_ack_o  out  NUM_MASTERS  per-master ACK.
- m_err_o  out  NUM_MASTERS  per-master timeout error pulse.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave control.
- s_adr_o  out  ADDR_WIDTH  slave address.
- s_dat_o  out  DATA_WIDTH  slave write data.
- s_sel_o  out  SEL_WIDTH  slave byte select.
- s_dat_i  in  DATA_WIDTH  slave read data.
- s_ack_i  in  1  slave ACK.
- grant_o  out  NUM_MASTERS  one-hot registered grant; all zero when idle.
- busy_o  out  1  high in BUSY.

## Operation

- FSM has two states, IDLE and BUSY. Reset puts it in IDLE with grant_o = 0, priority pointer = 0, watchdog = 0, m_err_o = 0. All slave outputs read 0 and m_ack_o = 0.
- IDLE:
  - If any m_cyc_i is high, select the first requester found by searching from the pointer upward (modulo NUM_MASTERS).
  - Register its one-hot grant and go to BUSY.
  - If no m_cyc_i is high, stay in IDLE.
- BUSY:
  - s_cyc_o, s_we_o, s_adr_o, s_dat_o and s_sel_o are muxed combinationally from the granted master.
  - s_stb_o = granted m_stb_i AND NOT err_mask.
  - m_ack_o[g] = s_ack_i in BUSY only; all other m_ack_o bits are 0.
- Release: when granted m_cyc_i is low at a clock edge:
  - go to IDLE;
  - clear grant;
  - set pointer = g+1 mod NUM_MASTERS.
  - The released master therefore has lowest priority in the next arbitration.
- Outside BUSY, slave outputs are forced to 0 and s_ack_i is ignored.
- Watchdog (TIMEOUT_CYCLES > 0):
  - Counter increments each BUSY cycle with granted stb high and s_ack_i low.
  - It clears on s_ack_i, on stb low, or on leaving BUSY.
  - When it reaches TIMEOUT_CYCLES, m_err_o[g] is registered high for exactly one cycle and the counter clears.
  - During that cycle err_mask forces s_stb_o low.
  - Grant is retained; the master is expected to drop CYC.
- s_ack_i arriving in the same cycle the counter would expire takes precedence: ACK is delivered, no error is raised.
- m_dat_o is a plain wire copy of s_dat_i.

## Timing

- Grant latency: m_cyc_i rising before edge N → grant_o and s_cyc_o valid after edge N. The first slave cycle is therefore one clock after the request.
- Release costs one dead cycle: after the edge that samples CYC low, the slave bus is idle for one cycle before the next grant is taken.
- Back-to-back transfers of the granted master under one CYC incur no arbitration gap.
- ACK path from s_ack_i to m_ack_o is combinational: zero added latency.
- Timeout: with stb asserted from cycle 0 and no ACK, m_err_o is high in cycle TIMEOUT_CYCLES.
- Simultaneous requests are resolved only by the pointer. A request arriving during BUSY waits until release.
- wb_rst asserted mid-transfer: all outputs drop to reset values immediately, without waiting for a clock edge. The in-flight transfer is abandoned.

## Test plan

- Single write by master 0: adr 0x10, dat 0xDEADBEEF, sel 0xF; slave ACKs 2 cycles after stb.
  → grant_o = 01 one cycle after cyc; s_adr_o = 0x10; s_dat_o = 0xDEADBEEF; one m_ack_o[0] pulse; m_ack_o[1] stays 0.
- NUM_MASTERS=2, both masters request single reads continuously from reset, slave ACKs immediately.
  → grant order 0,1,0,1; one idle cycle between grants; each master sees only its own ACKs.
- Master 1 holds CYC for 3 back-to-back writes (0x100, 0x104, 0x108) while master 0 requests.
  → all three reach the slave consecutively; master 0 is granted only after master 1 drops CYC, plus one idle cycle.
- TIMEOUT_CYCLES=8, slave never ACKs a read from master 1.
  → m_err_o[1] is a single pulse 8 cycles after stb; s_stb_o is low that cycle; no m_ack_o; after CYC drops, master 0 can win.
- ACK and timeout in the same cycle (slave ACKs in cycle 8 with TIMEOUT_CYCLES=8).
  → m_ack_o pulses and m_err_o stays 0.
- wb_rst asserted between clock edges during a granted transfer.
  → grant_o, s_cyc_o, s_stb_o and busy_o are 0 before the next edge; after release, the first arbitration with both masters requesting picks master 0.
